count_ones_stream: RTL and testbench

- Parametrised, pipelined successor to the single-word popcount block.
- Counts set bits of BITS-wide words arriving on a valid/ready stream and returns the per-word count two cycles later.
- Also keeps a saturating running total of ones across a frame delimited by in_last.
- Sits between the switch/stimulus source and LED/display or downstream statistics logic.

---
 rtl/count_ones_pkg.sv | 34 +++
 rtl/popcount_leaf.sv | 30 +++
 rtl/count_ones_stream.sv | 188 ++++++++++++++++++
 tb/tb_count_ones_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_ones_pkg.sv
// -----------------------------------------------------------------------------
// count_ones_pkg
//
// Shared definitions for the count_ones_stream popcount pipeline.
//   cw(bits)              : width needed to hold a count of 0..bits.
//   n_leaves(bits, chunk) : number of leaf counters, ceil(bits/chunk).
//   s1_t                  : stage-1 register contents (leaf counts, last, valid).
//
// s1_t is sized for the widest legal configuration (256 one-bit leaves, each
// holding a count up to 256). A given instance only ever writes the first
// n_leaves entries; the rest are reset to zero and reloaded with zero, so they
// are constants and disappear in synthesis.
// -----------------------------------------------------------------------------
package count_ones_pkg;

    localparam int MAX_BITS   = 256;
    localparam int MAX_LEAVES = MAX_BITS;
    localparam int LEAF_W     = $clog2(MAX_BITS + 1);

    function automatic int cw(input int bits);
        return $clog2(bits + 1);
    endfunction

    function automatic int n_leaves(input int bits, input int chunk);
        return (bits + chunk - 1) / chunk;
    endfunction

    typedef struct packed {
        logic [MAX_LEAVES-1:0][LEAF_W-1:0] leaf;
        logic                              last;
        logic                              valid;
    } s1_t;

endpackage

// File: rtl/popcount_leaf.sv
// -----------------------------------------------------------------------------
// popcount_leaf
//
// Purely combinational population count of one CHUNK-bit slice.
//
// Parameters:
//   CHUNK : slice width in bits (>= 1).
// Ports:
//   data  in  CHUNK        slice to count
//   count out cw(CHUNK)    number of set bits in data
// -----------------------------------------------------------------------------
module popcount_leaf
    import count_ones_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]     data,
    output logic [cw(CHUNK)-1:0] count
);

    localparam int LW = cw(CHUNK);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + LW'(data[i]);
        end
    end

endmodule

// File: rtl/count_ones_stream.sv
// -----------------------------------------------------------------------------
// count_ones_stream
//
// Two-stage pipelined popcount on a valid/ready stream with a saturating
// per-frame running total.
//
//   Stage 1 : leaf popcounts of CHUNK-bit slices of in_data (last slice
//             zero-padded), registered together with in_last and in_valid.
//   Stage 2 : leaf counts summed into out_count; frame total updated with
//             saturation at 2^ACC_W-1 and a sticky saturation flag.
//
// The whole pipe advances on en = !out_valid || out_ready, and in_ready = en,
// so a stalled output freezes every stage and all outputs hold stable.
// A word driven in one cycle is transferred at the next edge and its result
// appears on out_* after the edge after that.
//
// Parameters:
//   BITS  : input word width (1..256)
//   CHUNK : bits per leaf counter (1..BITS)
//   ACC_W : width of the frame running total
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous reset, active low
//   in_valid         in   input word valid
//   in_ready         out  block can accept a word
//   in_data          in   BITS-bit word to count
//   in_last          in   word is the final beat of its frame
//   out_valid        out  result valid
//   out_ready        in   downstream accepts the result
//   out_count        out  ones in the word (cw(BITS) bits)
//   out_total        out  running frame total including this word (ACC_W bits)
//   out_last         out  in_last of this word
//   out_sat          out  out_total has saturated somewhere in this frame
//
// Optional build macro COUNT_ONES_STREAM_PARITY_EN adds:
//   out_parity       out  XOR of the word (equals out_count[0])
//   out_frame_parity out  XOR of every word of the frame so far
// -----------------------------------------------------------------------------
module count_ones_stream
    import count_ones_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int CHUNK = 4,
    parameter int ACC_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [cw(BITS)-1:0] out_count,
    output logic [ACC_W-1:0]    out_total,
    output logic                out_last,
    output logic                out_sat
`ifdef COUNT_ONES_STREAM_PARITY_EN
    ,
    output logic                out_parity,
    output logic                out_frame_parity
`endif
);

    localparam int CW    = cw(BITS);
    localparam int NL    = n_leaves(BITS, CHUNK);
    localparam int LW    = cw(CHUNK);
    // Wide enough that base + count never wraps, whichever operand is wider.
    localparam int SUM_W = ((ACC_W > CW) ? ACC_W : CW) + 1;

    // Saturating frame add: returns {saturated, clipped_total}.
    function automatic logic [ACC_W:0] frame_add(input logic [ACC_W-1:0] base,
                                                 input logic [CW-1:0]    cnt);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] lim;
        sum = SUM_W'(base) + SUM_W'(cnt);
        lim = SUM_W'({ACC_W{1'b1}});
        if (sum > lim) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- stage 0 : leaf popcounts of the incoming word ----------
    logic [NL*CHUNK-1:0]   padded_p0;
    logic [NL-1:0][LW-1:0] leaf_cnt_p0;
    s1_t                   s1_d_p0;

    always_comb begin
        padded_p0            = '0;
        padded_p0[BITS-1:0]  = in_data;
    end

    for (genvar g = 0; g < NL; g++) begin : g_leaf
        popcount_leaf #(
            .CHUNK (CHUNK)
        ) u_leaf (
            .data  (padded_p0[g*CHUNK +: CHUNK]),
            .count (leaf_cnt_p0[g])
        );
    end

    always_comb begin
        s1_d_p0 = '0;
        for (int i = 0; i < NL; i++) begin
            s1_d_p0.leaf[i] = LEAF_W'(leaf_cnt_p0[i]);
        end
        // in_last is meaningless without in_valid; keep it clean in the pipe.
        s1_d_p0.last  = in_valid & in_last;
        s1_d_p0.valid = in_valid;
    end

    // ---------------- stage 1 register ---------------------------------------
    s1_t s1_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_p1 <= '0;
        end else if (en) begin
            s1_p1 <= s1_d_p0;
        end
    end

    // ---------------- stage 1 -> 2 : sum leaves, update frame total ----------
    logic [CW-1:0]    word_cnt_p1;
    logic             frame_first;   // next valid word opens a new frame
    logic [ACC_W-1:0] base_p1;
    logic [ACC_W:0]   add_p1;
    logic             sat_next_p1;

    // Unused leaf entries are held at zero, so summing all of them is exact.
    always_comb begin
        word_cnt_p1 = '0;
        for (int i = 0; i < MAX_LEAVES; i++) begin
            word_cnt_p1 = word_cnt_p1 + CW'(s1_p1.leaf[i]);
        end
    end

    // out_total doubles as the accumulator: it always holds the total of the
    // most recent valid word, which is exactly the base for the next one.
    assign base_p1     = frame_first ? '0 : out_total;
    assign add_p1      = frame_add(base_p1, word_cnt_p1);
    assign sat_next_p1 = add_p1[ACC_W] | (!frame_first & out_sat);

    // ---------------- stage 2 register (outputs) -----------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_count   <= '0;
            out_total   <= '0;
            out_last    <= 1'b0;
            out_sat     <= 1'b0;
            frame_first <= 1'b1;
        end else if (en) begin
            out_valid <= s1_p1.valid;
            if (s1_p1.valid) begin
                out_count   <= word_cnt_p1;
                out_total   <= add_p1[ACC_W-1:0];
                out_last    <= s1_p1.last;
                out_sat     <= sat_next_p1;
                frame_first <= s1_p1.last;
            end
        end
    end

`ifdef COUNT_ONES_STREAM_PARITY_EN
    logic frame_par_next_p1;

    assign frame_par_next_p1 = (frame_first ? 1'b0 : out_frame_parity) ^ word_cnt_p1[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_parity       <= 1'b0;
            out_frame_parity <= 1'b0;
        end else if (en && s1_p1.valid) begin
            out_parity       <= word_cnt_p1[0];
            out_frame_parity <= frame_par_next_p1;
        end
    end
`endif

endmodule

// File: tb/tb_count_ones_stream.sv
// -----------------------------------------------------------------------------
// tb_count_ones_stream
//
// Three instances share clk/rst:
//   u_a : BITS=16 CHUNK=4 ACC_W=16   directed vectors
//   u_b : BITS=16 CHUNK=4 ACC_W=5    same inputs as u_a, saturation behaviour
//   u_c : BITS=10 CHUNK=4 ACC_W=8    random stream with random out_ready
// A reference model tracks accepted words per frame with plain integer sums
// and checks every output transfer; directed tables add fixed expectations.
// -----------------------------------------------------------------------------
module tb_count_ones_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_last, out_ready;
    logic [15:0] in_data;

    logic        a_in_ready, a_out_valid, a_out_last, a_out_sat;
    logic [4:0]  a_out_count;
    logic [15:0] a_out_total;

    logic        b_in_ready, b_out_valid, b_out_last, b_out_sat;
    logic [4:0]  b_out_count;
    logic [4:0]  b_out_total;

    logic        c_in_valid, c_in_last, c_out_ready;
    logic [9:0]  c_in_data;
    logic        c_in_ready, c_out_valid, c_out_last, c_out_sat;
    logic [3:0]  c_out_count;
    logic [7:0]  c_out_total;

`ifdef COUNT_ONES_STREAM_PARITY_EN
    logic a_par, a_fpar, b_par, b_fpar, c_par, c_fpar;
`endif

    count_ones_stream #(.BITS(16), .CHUNK(4), .ACC_W(16)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_count(a_out_count),
        .out_total(a_out_total), .out_last(a_out_last), .out_sat(a_out_sat)
`ifdef COUNT_ONES_STREAM_PARITY_EN
        , .out_parity(a_par), .out_frame_parity(a_fpar)
`endif
    );

    count_ones_stream #(.BITS(16), .CHUNK(4), .ACC_W(5)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_count(b_out_count),
        .out_total(b_out_total), .out_last(b_out_last), .out_sat(b_out_sat)
`ifdef COUNT_ONES_STREAM_PARITY_EN
        , .out_parity(b_par), .out_frame_parity(b_fpar)
`endif
    );

    count_ones_stream #(.BITS(10), .CHUNK(4), .ACC_W(8)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_last(c_in_last),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_count(c_out_count),
        .out_total(c_out_total), .out_last(c_out_last), .out_sat(c_out_sat)
`ifdef COUNT_ONES_STREAM_PARITY_EN
        , .out_parity(c_par), .out_frame_parity(c_fpar)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // tot is the unclipped frame sum; clipping/saturation is derived at compare.
    typedef struct { int cnt; int tot; logic last; } exp_t;
    typedef struct { int cnt; int ta; logic el; int tb; logic sb; } obs_t;

    exp_t exp_ab[$];
    exp_t exp_c[$];
    obs_t obs_q[$];
    bit   first_ab = 1'b1, first_c = 1'b1;
    int   run_ab = 0, run_c = 0;
    int   n_in_ab = 0, n_out_ab = 0, n_in_c = 0, n_out_c = 0;

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        obs_t o;
        if (!rst) begin
            exp_ab.delete();
            first_ab = 1'b1;
        end else begin
            if (a_out_valid && out_ready) begin
                if (exp_ab.size() == 0) begin
                    chk("ab_unexpected_output", 1, 0);
                end else begin
                    e = exp_ab.pop_front();
                    n_out_ab++;
                    chk("a_count", a_out_count, e.cnt);
                    chk("a_total", a_out_total, clip(e.tot, 65535));
                    chk("a_last",  a_out_last, e.last);
                    chk("a_sat",   a_out_sat, e.tot > 65535);
                    chk("b_valid", b_out_valid, 1);
                    chk("b_count", b_out_count, e.cnt);
                    chk("b_total", b_out_total, clip(e.tot, 31));
                    chk("b_last",  b_out_last, e.last);
                    chk("b_sat",   b_out_sat, e.tot > 31);
`ifdef COUNT_ONES_STREAM_PARITY_EN
                    chk("a_parity",       a_par,  e.cnt & 1);
                    chk("a_frame_parity", a_fpar, e.tot & 1);
                    chk("b_parity",       b_par,  e.cnt & 1);
                    chk("b_frame_parity", b_fpar, e.tot & 1);
`endif
                    o.cnt = a_out_count; o.ta = a_out_total; o.el = a_out_last;
                    o.tb  = b_out_total; o.sb = b_out_sat;
                    obs_q.push_back(o);
                end
            end
            if (in_valid && a_in_ready) begin
                if (first_ab) run_ab = 0;
                run_ab += $countones(in_data);
                e.cnt = $countones(in_data); e.tot = run_ab; e.last = in_last;
                exp_ab.push_back(e);
                first_ab = in_last;
                n_in_ab++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_c.delete();
            first_c = 1'b1;
        end else begin
            if (c_out_valid && c_out_ready) begin
                if (exp_c.size() == 0) begin
                    chk("c_unexpected_output", 1, 0);
                end else begin
                    e = exp_c.pop_front();
                    n_out_c++;
                    chk("c_count", c_out_count, e.cnt);
                    chk("c_total", c_out_total, clip(e.tot, 255));
                    chk("c_last",  c_out_last, e.last);
                    chk("c_sat",   c_out_sat, e.tot > 255);
`ifdef COUNT_ONES_STREAM_PARITY_EN
                    chk("c_parity",       c_par,  e.cnt & 1);
                    chk("c_frame_parity", c_fpar, e.tot & 1);
`endif
                end
            end
            if (c_in_valid && c_in_ready) begin
                if (first_c) run_c = 0;
                run_c += $countones(c_in_data);
                e.cnt = $countones(c_in_data); e.tot = run_c; e.last = c_in_last;
                exp_c.push_back(e);
                first_c = c_in_last;
                n_in_c++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        while (!(a_in_ready && b_in_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!(a_in_ready && b_in_ready)) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain_ab();
        int t;
        t = 0;
        while (exp_ab.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_ab.size() != 0) chk("drain_ab_timeout", exp_ab.size(), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] d; logic l;
        int cnt; int ta; logic el; int tb; logic sb;
    } vec_t;

    vec_t        tbl[11];
    logic [15:0] bp_words[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{16'hFFFF, 1'b0, 16, 16, 1'b0, 16, 1'b0};
        tbl[1]  = '{16'h0000, 1'b0,  0, 16, 1'b0, 16, 1'b0};
        tbl[2]  = '{16'h8001, 1'b1,  2, 18, 1'b1, 18, 1'b0};
        tbl[3]  = '{16'h000F, 1'b1,  4,  4, 1'b1,  4, 1'b0};
        tbl[4]  = '{16'h00FF, 1'b0,  8,  8, 1'b0,  8, 1'b0};
        tbl[5]  = '{16'h0000, 1'b1,  0,  8, 1'b1,  8, 1'b0};
        tbl[6]  = '{16'hFFFF, 1'b0, 16, 16, 1'b0, 16, 1'b0};
        tbl[7]  = '{16'hFFFF, 1'b0, 16, 32, 1'b0, 31, 1'b1};
        tbl[8]  = '{16'h0001, 1'b1,  1, 33, 1'b1, 31, 1'b1};
        tbl[9]  = '{16'h0007, 1'b1,  3,  3, 1'b1,  3, 1'b0};
        tbl[10] = '{16'hF0F0, 1'b0,  8,  8, 1'b0,  8, 1'b0};
        bp_words = '{16'h1234, 16'hAAAA, 16'h0F0F, 16'hFFFE, 16'h8000, 16'h7FFF};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_out_ready = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_out_count", a_out_count, 0);
        chk("reset_out_total", a_out_total, 0);
        chk("reset_out_last",  a_out_last, 0);
        chk("reset_out_sat",   a_out_sat, 0);
        chk("reset_c_valid",   c_out_valid, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Latency: single-beat frame, driven after edge E, result after E+2.
        in_valid = 1'b1; in_data = 16'h0101; in_last = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", a_in_ready, 1);
        chk("lat_valid_e0", a_out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("lat_valid_e1", a_out_valid, 0);
        @(negedge clk);
        chk("lat_valid_e2", a_out_valid, 1);
        chk("lat_count",    a_out_count, 2);
        chk("single_beat_total", a_out_total, 2);
        @(posedge clk); #1;
        drain_ab();

        // Table-driven directed vectors, full throughput.
        obs_q.delete();
        foreach (tbl[i]) send(tbl[i].d, tbl[i].l);
        drain_ab();
        chk("tbl_n_results", obs_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < obs_q.size()) begin
                chk($sformatf("tbl%0d_count", i),   obs_q[i].cnt, tbl[i].cnt);
                chk($sformatf("tbl%0d_total_a", i), obs_q[i].ta,  tbl[i].ta);
                chk($sformatf("tbl%0d_last", i),    obs_q[i].el,  tbl[i].el);
                chk($sformatf("tbl%0d_total_b", i), obs_q[i].tb,  tbl[i].tb);
                chk($sformatf("tbl%0d_sat_b", i),   obs_q[i].sb,  tbl[i].sb);
            end
        end

        // Backpressure: out_ready low for three cycles mid-stream.
        fork
            begin
                for (int k = 0; k < 6; k++) send(bp_words[k], k == 5);
            end
            begin
                @(posedge clk); @(posedge clk); #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", a_in_ready, 0);
                    chk("bp_out_valid", a_out_valid, 1);
                    if (exp_ab.size() > 0) chk("bp_hold_count", a_out_count, exp_ab[0].cnt);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain_ab();
        chk("bp_no_loss_or_dup", n_out_ab, n_in_ab);

        // Reset mid-frame.
        obs_q.delete();
        send(16'h00F0, 1'b0);
        send(16'h0F00, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_total", a_out_total, 0);
        chk("midrst_out_sat",   b_out_sat, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_idle_valid", a_out_valid, 0);
        end
        @(posedge clk); #1;
        send(16'h0003, 1'b1);
        drain_ab();
        chk("midrst_n_results", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("midrst_count", obs_q[0].cnt, 2);
            chk("midrst_total", obs_q[0].ta, 2);
        end

        // Random stream on the BITS=10 instance.
        for (int k = 0; k < 1000; k++) begin
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_in_data   = 10'($urandom);
            c_in_last   = ($urandom_range(0, 63) == 0);
            c_out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0; c_in_last = 1'b0; c_out_ready = 1'b1;
        begin
            int t;
            t = 0;
            while (exp_c.size() != 0 && t < 100) begin
                @(posedge clk);
                t++;
            end
            if (exp_c.size() != 0) chk("drain_c_timeout", exp_c.size(), 0);
        end
        @(posedge clk); #1;
        chk("c_no_loss_or_dup", n_out_c, n_in_c);
        chk("c_enough_traffic", n_out_c > 400, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
